// File: rtl/fir_pkg.sv
// Shared FIR-core definitions: coefficient-memory geometry, controller states
// and the tap-count to phase-count helper.
package fir_pkg;

    localparam int unsigned CMEM_AW = 6;
    localparam int unsigned CMEM_DW = 16;
    localparam int unsigned CMEM_NB = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } cmem_state_t;

    // Number of 8-tap read phases needed to cover n taps.
    function automatic logic [3:0] phases(input logic [CMEM_AW:0] n);
        logic [7:0] sum;
        sum = 8'(n) + 8'd7;
        return 4'(sum >> 3);
    endfunction

endpackage

// File: rtl/cmem_seq.sv
// Coefficient-memory controller: loads taps from a valid/ready stream into the
// replicated banks, then sequences per-sample read phases for the MAC.
module cmem_seq
    import fir_pkg::*;
#(
    parameter int unsigned AW = CMEM_AW,
    parameter int unsigned DW = CMEM_DW,
    parameter int unsigned NB = CMEM_NB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic [AW:0]        num_taps,
    input  logic [DW-1:0]      coef_data,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               busy,
    output logic [DW-1:0]      mem_d,
    output logic [NB*AW-1:0]   mem_addr,
    output logic               mem_wen,
    output logic               mem_cen,
    output logic               coef_vld,
    output logic [2:0]         coef_phase,
    output logic               coef_first,
    output logic               coef_last,
    output logic [NB-1:0]      tap_mask
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = 3;
    localparam logic [CW-1:0] DEPTH = CW'(1 << AW);

    cmem_state_t state, state_next;

    logic [CW-1:0]    ntaps_q;
    logic [CW-1:0]    nload_q;
    logic [CW-1:0]    wptr_q;
    logic [PW-1:0]    phase_q;

    // Issue-stage flags and strobes, one cycle ahead of the memory enables.
    logic             wr_iss_q;
    logic             rd_iss_q;
    logic [PW-1:0]    s1_phase_q;
    logic             s1_first_q;
    logic             s1_last_q;
    logic [NB-1:0]    s1_mask_q;

    logic             load_go_c;
    logic [CW-1:0]    load_n_c;
    logic             wr_fire_c;
    logic             wr_done_c;
    logic             sample_go_c;
    logic             rd_fire_c;
    logic             rd_last_c;
    logic [NB-1:0]    mask_c;
    logic [NB*AW-1:0] addr_c;

    assign sample_ready = (state == ST_IDLE) && (ntaps_q != '0) && !load_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_go_c) begin
                    if (load_n_c != '0) state_next = ST_LOAD;
                end else if (sample_go_c) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: if (wr_done_c) state_next = ST_IDLE;
            ST_RUN:  if (rd_last_c) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/decode logic feeding the registered datapath
    always_comb begin
        load_go_c   = (state == ST_IDLE) && load_start;
        load_n_c    = (num_taps > DEPTH) ? DEPTH : num_taps;
        wr_fire_c   = (state == ST_LOAD) && coef_valid && coef_ready;
        wr_done_c   = wr_fire_c && ((wptr_q + CW'(1)) == nload_q);
        sample_go_c = sample_valid && sample_ready;
        rd_fire_c   = (state == ST_RUN);
        rd_last_c   = rd_fire_c && ((4'(phase_q) + 4'd1) == phases(ntaps_q));
        mask_c      = '0;
        addr_c      = '0;
        for (int i = 0; i < NB; i++) begin
            mask_c[i]         = CW'(32'(phase_q) * NB + 32'(i)) < ntaps_q;
            addr_c[AW*i +: AW] = AW'(32'(phase_q) * NB + 32'(i));
        end
    end

    // Registered datapath and memory/consumer interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ntaps_q    <= '0;
            nload_q    <= '0;
            wptr_q     <= '0;
            phase_q    <= '0;
            wr_iss_q   <= 1'b0;
            rd_iss_q   <= 1'b0;
            s1_phase_q <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mask_q  <= '0;
            coef_ready <= 1'b0;
            busy       <= 1'b0;
            mem_d      <= '0;
            mem_addr   <= '0;
            mem_wen    <= 1'b1;
            mem_cen    <= 1'b1;
            coef_vld   <= 1'b0;
            coef_phase <= '0;
            coef_first <= 1'b0;
            coef_last  <= 1'b0;
            tap_mask   <= '0;
        end else begin
            coef_ready <= (state_next == ST_LOAD);
            busy       <= (state_next != ST_IDLE);

            if (load_go_c) begin
                if (load_n_c == '0) begin
                    ntaps_q <= '0;
                end else begin
                    wptr_q  <= '0;
                    nload_q <= load_n_c;
                end
            end

            if (wr_fire_c) begin
                mem_d    <= coef_data;
                mem_addr <= {NB{wptr_q[AW-1:0]}};
                wptr_q   <= wptr_q + CW'(1);
                if (wr_done_c) ntaps_q <= nload_q;
            end

            if (sample_go_c) phase_q <= '0;

            if (rd_fire_c) begin
                mem_addr <= addr_c;
                phase_q  <= phase_q + PW'(1);
            end

            wr_iss_q   <= wr_fire_c;
            rd_iss_q   <= rd_fire_c;
            s1_phase_q <= rd_fire_c ? phase_q : '0;
            s1_first_q <= rd_fire_c && (phase_q == '0);
            s1_last_q  <= rd_last_c;
            s1_mask_q  <= rd_fire_c ? mask_c : '0;

            // WEN/CEN are sampled by the memory one cycle after A/D.
            mem_wen    <= !wr_iss_q;
            mem_cen    <= !(wr_iss_q || rd_iss_q);
            coef_vld   <= rd_iss_q;
            coef_phase <= s1_phase_q;
            coef_first <= s1_first_q;
            coef_last  <= s1_last_q;
            tap_mask   <= s1_mask_q;
        end
    end

endmodule

// File: doc/cmem_seq.md
Name: cmem_seq

Overview:
- Controller directly upstream of the coefficient memory in the FIR core.
- Loads up to 64 coefficients from a valid/ready stream into all eight replicated memory banks.
- Per accepted sample, sequences read phases that present 8 consecutive taps per cycle to the downstream MAC.
- Generates the memory address, data, WEN and CEN timing, plus per-phase tap-valid strobes for the consumer.

Parameters:
AW, 6, memory address width (depth 2^AW = 64)
DW, 16, coefficient width
NB, 8, number of banks / taps per phase

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
load_start  in  1  begin coefficient load (honoured only in IDLE)
num_taps  in  AW+1  tap count N, sampled with load_start
coef_data  in  DW  coefficient stream data
coef_valid  in  1  stream valid
coef_ready  out  1  stream ready
sample_valid  in  1  new input sample, request one filter pass
sample_ready  out  1  pass may start
busy  out  1  state != IDLE
mem_d  out  DW  write data to memory D
mem_addr  out  NB*AW  bank i address = [AW*i+AW-1 : AW*i]
mem_wen  out  1  write enable, active-low
mem_cen  out  1  chip enable, active-low
coef_vld  out  1  memory outputs Q0..Q7 valid for capture at next rising edge
coef_phase  out  3  phase index p of presented taps
coef_first  out  1  first phase of a pass
coef_last  out  1  last phase of a pass
tap_mask  out  NB  bit i set when tap 8p+i < N

Behaviour:
- Reset, async and active-high. Outputs go to:
  - mem_wen=1, mem_cen=1, mem_addr=0, mem_d=0
  - coef_ready=0, sample_ready=0, coef_vld=0, coef_first=0, coef_last=0, coef_phase=0, tap_mask=0, busy=0
  - state=IDLE, ntaps_q=0
- Reset mid-load or mid-pass discards progress. ntaps_q=0 forces a reload before any pass.
- States are IDLE, LOAD and RUN.
- IDLE:
  - On load_start: N = min(num_taps, 64).
  - If N==0: ntaps_q=0 and stay in IDLE.
  - Otherwise: wptr=0 and go to LOAD.
  - load_start has priority over sample_valid in the same cycle.
- sample_ready = (state==IDLE) && (ntaps_q!=0) && !load_start.
- On a sample handshake: phase=0, go to RUN.
- LOAD:
  - coef_ready=1.
  - Each coef_valid&&coef_ready edge:
    - mem_d <= coef_data
    - every bank address <= wptr
    - wptr++
  - After the N-th handshake: ntaps_q=N, go to IDLE, coef_ready drops in the following cycle.
  - Gaps in coef_valid produce no write.
  - load_start and sample_valid are ignored in LOAD and RUN.
- Memory timing: the memory registers A/D on the rising edge, but samples WEN/CEN unregistered during the next cycle.
  - mem_wen and mem_cen are registered and lag mem_addr/mem_d by exactly one cycle.
  - Write cycle: mem_wen=0, mem_cen=0.
  - Read cycle: mem_wen=1, mem_cen=0.
  - Otherwise: both 1.
- RUN:
  - P = ceil(ntaps_q/8), range 1..8.
  - Each cycle issue phase p: bank i address = 8p+i (always ≤63, no wrap).
  - After p==P-1: go to IDLE.
- Consumer strobes: coef_vld, coef_phase, coef_first, coef_last and tap_mask are issue-cycle values delayed one cycle, coincident with mem_cen=0.
  - coef_first is asserted when p==0.
  - coef_last is asserted when p==P-1.
  - For P==1 both are asserted together.
  - tap_mask[i] = (8p+i < ntaps_q).
- Throughput: one pass occupies P issue cycles plus a return to IDLE, so the next sample is accepted no earlier than P+1 cycles after the previous handshake.
- mem_d retains its last write value during RUN.

Decomposition:
- Shared package fir_pkg holds:
  - constants CMEM_AW=6, CMEM_DW=16, CMEM_NB=8
  - the state enum
  - function phases(n) = (n+7)>>3
- No sub-module; single flat module with a one-stage strobe-delay register bank.

Test Plan:
- Reset asserted mid-cycle → all outputs at reset values immediately (async), sample_ready=0.
- Load N=5, data 0x1111..0x5555, coef_valid low every other cycle → bank addresses 0..4 in order, mem_wen=0 exactly one cycle after each address, 5 writes, coef_ready falls, sample_ready=1.
- N=5, one sample → one issue cycle, addresses 0..7, next cycle coef_vld=1, phase 0, first=last=1, tap_mask=0x1F, mem_cen=0, mem_wen=1.
- N=13, sample_valid held high → phases 0,1 with tap_mask 0xFF then 0x1F. Second handshake occurs exactly 3 cycles after the first.
- num_taps=0 → stays IDLE, sample_ready=0. num_taps=100 → clamps to 64, 64 writes; a pass gives 8 phases, phase 7 addresses 56..63, mask 0xFF.
- Reset after 3 of 10 writes → ntaps_q=0, sample_ready=0. A fresh load of N=10 then succeeds from address 0.
